// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial adder.
// The adder uses one full-adder cell and a carry flop, LSB first.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             prio_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic             carry_r;
    logic             cout_r;
    logic             id_r;
    logic             done_id_r;
    logic [CW-1:0]    cnt_r;
    logic             win1_s;
    logic             last_s;
    logic             fa_sum_s;
    logic             fa_cout_s;

    // {carry, sum} of a single full-adder cell
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Arbitration, grant strobes, serial add cell and next-state decode
    always_comb begin
        state_nxt_s            = state_r;
        gnt0                   = 1'b0;
        gnt1                   = 1'b0;
        win1_s                 = req1 & (~req0 | prio_r);
        {fa_cout_s, fa_sum_s}  = full_add(opa_r[0], opb_r[0], carry_r);
        res_nxt_s              = WIDTH'({fa_sum_s, res_r} >> 1);
        last_s                 = (cnt_r == CW'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                // Grants are suppressed while reset is asserted so no job starts on a reset edge.
                if (!rst && (req0 || req1)) begin
                    gnt0        = ~win1_s;
                    gnt1        = win1_s;
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, serial datapath and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r    <= 1'b0;
            opa_r     <= '0;
            opb_r     <= '0;
            res_r     <= '0;
            sum_r     <= '0;
            carry_r   <= 1'b0;
            cout_r    <= 1'b0;
            id_r      <= 1'b0;
            done_id_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        opa_r   <= win1_s ? a1 : a0;
                        opb_r   <= win1_s ? b1 : b0;
                        carry_r <= win1_s ? cin1 : cin0;
                        id_r    <= win1_s;
                        prio_r  <= ~win1_s;
                        cnt_r   <= '0;
                    end
                end
                ADD: begin
                    opa_r   <= opa_r >> 1;
                    opb_r   <= opb_r >> 1;
                    res_r   <= res_nxt_s;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    // Publish on entry to DONE so the result is visible during the done strobe.
                    if (last_s) begin
                        sum_r     <= res_nxt_s;
                        cout_r    <= fa_cout_s;
                        done_id_r <= id_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state_r != IDLE);
    assign done    = (state_r == DONE);
    assign sum     = sum_r;
    assign cout    = cout_r;
    assign done_id = done_id_r;

endmodule
